// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op/state encodings and width default for mult_div_unit
package mult_div_unit_pkg;

  localparam int SIZE_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiply / restoring divide with HI/LO result
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int size = SIZE_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [size-1:0] src1_i,
  input  logic [size-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [size-1:0] hi_o,
  output logic [size-1:0] lo_o,
  output logic            div_zero_o
);

  localparam int CW = $clog2(size);

  state_e              state;
  logic [2*size-1:0]   acc;
  logic [size-1:0]     opnd;
  logic [CW-1:0]       cnt;
  logic                is_div;
  logic                res_neg;
  logic                rem_neg;

  op_e                 op;
  logic                op_is_div;
  logic                neg1;
  logic                neg2;
  logic [size-1:0]     mag1;
  logic [size-1:0]     mag2;

  logic [size:0]       sum;
  logic [size:0]       rem;
  logic [size:0]       diff;
  logic [2*size-1:0]   step_acc;
  logic [2*size-1:0]   prod_fin;
  logic [size-1:0]     quo_fin;
  logic [size-1:0]     rem_fin;

  // Signed ops run on magnitudes; the most-negative value stays a valid unsigned magnitude.
  always_comb begin
    op        = op_e'(op_i);
    op_is_div = (op == OP_DIVU) || (op == OP_DIV);
    neg1      = (op == OP_MULT || op == OP_DIV) && src1_i[size-1];
    neg2      = (op == OP_MULT || op == OP_DIV) && src2_i[size-1];
    mag1      = neg1 ? (~src1_i + 1'b1) : src1_i;
    mag2      = neg2 ? (~src2_i + 1'b1) : src2_i;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum  = {1'b0, acc[2*size-1:size]} + {1'b0, opnd};
    rem  = {acc[2*size-1:size], acc[size-1]};
    diff = rem - {1'b0, opnd};
    step_acc = acc;
    if (!is_div) begin
      if (acc[0]) step_acc = {sum, acc[size-1:1]};
      else        step_acc = {1'b0, acc[2*size-1:1]};
    end else if (!diff[size]) begin
      step_acc = {diff[size-1:0], acc[size-2:0], 1'b1};
    end else begin
      step_acc = {rem[size-1:0], acc[size-2:0], 1'b0};
    end
    prod_fin = res_neg ? (~step_acc + 1'b1) : step_acc;
    quo_fin  = res_neg ? (~step_acc[size-1:0] + 1'b1) : step_acc[size-1:0];
    rem_fin  = rem_neg ? (~step_acc[2*size-1:size] + 1'b1) : step_acc[2*size-1:size];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      is_div     <= 1'b0;
      res_neg    <= 1'b0;
      rem_neg    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            is_div <= op_is_div;
            busy_o <= 1'b1;
            if (op_is_div && (src2_i == '0)) begin
              hi_o       <= src1_i;
              lo_o       <= '1;
              div_zero_o <= 1'b1;
              done_o     <= 1'b1;
              state      <= ST_DONE;
            end else begin
              acc     <= {{size{1'b0}}, mag1};
              opnd    <= mag2;
              res_neg <= neg1 ^ neg2;
              rem_neg <= neg1;
              cnt     <= CW'(size - 1);
              state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc <= step_acc;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            if (is_div) begin
              hi_o <= rem_fin;
              lo_o <= quo_fin;
            end else begin
              hi_o <= prod_fin[2*size-1:size];
              lo_o <= prod_fin[size-1:0];
            end
            div_zero_o <= 1'b0;
            done_o     <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
